// File: rtl/sprite_ram_dma_if.sv
// Signal bundle between the vblank sprite DMA engine, the CPU bus / work RAM
// source, and the mainboard sprite RAM write port.
interface sprite_ram_dma_if #(
  parameter int ADDR_W    = 11,
  parameter int REC_SHIFT = 2
);
  logic                      vblank_start;
  logic                      dma_ack;
  logic [7:0]                src_data;
  logic                      dma_req;
  logic                      src_rd;
  logic [ADDR_W-1:0]         src_addr;
  logic                      spr_we;
  logic [ADDR_W-1:0]         spr_addr;
  logic [7:0]                spr_data;
  logic                      busy;
  logic                      done;
  logic [ADDR_W-REC_SHIFT:0] rec_count;
  logic                      overrun;

  modport master (
    input  vblank_start, dma_ack, src_data,
    output dma_req, src_rd, src_addr, spr_we, spr_addr, spr_data,
           busy, done, rec_count, overrun
  );

  modport slave (
    output vblank_start, dma_ack, src_data,
    input  dma_req, src_rd, src_addr, spr_we, spr_addr, spr_data,
           busy, done, rec_count, overrun
  );
endinterface

// File: rtl/sprite_ram_dma.sv
// Vblank DMA: copies the sprite list from CPU work RAM into sprite RAM until the
// end-of-list marker or the last address. Define SPR_DMA_CLEAR_EN to zero-fill the tail.
module sprite_ram_dma #(
  parameter int         ADDR_W    = 11,
  parameter int         REC_SHIFT = 2,
  parameter logic [7:0] END_MARK  = 8'hFF
) (
  input  logic             master_clk,
  input  logic             nRESET,
  sprite_ram_dma_if.master bus
);
  localparam int                RC_W      = ADDR_W - REC_SHIFT + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] REC_MASK  = ADDR_W'((1 << REC_SHIFT) - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RUN,
`ifdef SPR_DMA_CLEAR_EN
    CLEAR,
`endif
    DONE
  } state_t;

  typedef struct packed {
    logic              dma_req;
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic              spr_we;
    logic [ADDR_W-1:0] spr_addr;
    logic [7:0]        spr_data;
    logic              busy;
    logic              done;
    logic [RC_W-1:0]   rec_count;
    logic              overrun;
  } out_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;   // MSB set once the final address has been read
  out_t            out_q, out_d;
  logic            is_first, is_mark, finish;

  always_ff @(posedge master_clk) begin
    // NOTE: reset is sampled on the clock edge; all state uses <= so every
    // register sees pre-edge values of the others.
    if (!nRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d       = state_q;
    ptr_d         = ptr_q;
    out_d         = out_q;
    out_d.src_rd  = 1'b0;
    out_d.spr_we  = 1'b0;
    out_d.done    = 1'b0;
    out_d.overrun = out_q.overrun | (bus.vblank_start & (state_q != IDLE));
    finish        = 1'b0;
    is_first      = out_q.spr_we && ((out_q.spr_addr & REC_MASK) == '0);
    is_mark       = is_first && (out_q.spr_data == END_MARK);

    case (state_q)
      IDLE: if (bus.vblank_start) begin
        state_d         = REQ;
        ptr_d           = '0;
        out_d.dma_req   = 1'b1;
        out_d.busy      = 1'b1;
        out_d.rec_count = '0;
      end
      REQ: if (bus.dma_ack) begin
        state_d        = RUN;
        out_d.src_rd   = 1'b1;
        out_d.src_addr = ptr_q[ADDR_W-1:0];
        ptr_d          = ptr_q + 1'b1;
      end
      RUN: begin
        if (is_first && !is_mark) out_d.rec_count = out_q.rec_count + 1'b1;
        // The marker write is visible now; any read issued alongside it is dropped.
        if (is_mark) begin
`ifdef SPR_DMA_CLEAR_EN
          if (out_q.spr_addr != LAST_ADDR) begin
            state_d        = CLEAR;
            out_d.dma_req  = 1'b0;
            out_d.spr_we   = 1'b1;
            out_d.spr_addr = out_q.spr_addr + 1'b1;
            out_d.spr_data = '0;
          end else begin
            finish = 1'b1;
          end
`else
          finish = 1'b1;
`endif
        end else if (out_q.spr_we && out_q.spr_addr == LAST_ADDR) begin
          finish = 1'b1;
        end else begin
          if (out_q.src_rd) begin
            out_d.spr_we   = 1'b1;
            out_d.spr_addr = out_q.src_addr;
            out_d.spr_data = bus.src_data;
          end
          if (bus.dma_ack && !ptr_q[ADDR_W]) begin
            out_d.src_rd   = 1'b1;
            out_d.src_addr = ptr_q[ADDR_W-1:0];
            ptr_d          = ptr_q + 1'b1;
          end
        end
      end
`ifdef SPR_DMA_CLEAR_EN
      CLEAR: begin
        if (out_q.spr_addr == LAST_ADDR) begin
          finish = 1'b1;
        end else begin
          out_d.spr_we   = 1'b1;
          out_d.spr_addr = out_q.spr_addr + 1'b1;
          out_d.spr_data = '0;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d       = DONE;
      out_d.dma_req = 1'b0;
      out_d.busy    = 1'b0;
      out_d.done    = 1'b1;
      out_d.spr_we  = 1'b0;
      out_d.src_rd  = 1'b0;
    end
  end

  assign bus.dma_req   = out_q.dma_req;
  assign bus.src_rd    = out_q.src_rd;
  assign bus.src_addr  = out_q.src_addr;
  assign bus.spr_we    = out_q.spr_we;
  assign bus.spr_addr  = out_q.spr_addr;
  assign bus.spr_data  = out_q.spr_data;
  assign bus.busy      = out_q.busy;
  assign bus.done      = out_q.done;
  assign bus.rec_count = out_q.rec_count;
  assign bus.overrun   = out_q.overrun;
endmodule

// File: tb/tb_sprite_ram_dma.sv
// Self-checking bench for sprite_ram_dma: expected write streams are derived
// from the source image and the list rules, then compared with captured writes.
module tb_sprite_ram_dma;
  localparam int ADDR_W    = 11;
  localparam int REC_SHIFT = 2;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int REC_BYTES = 1 << REC_SHIFT;
  localparam int LIMIT     = 6000;

  logic master_clk = 1'b0;
  logic nRESET     = 1'b0;
  always #5 master_clk = ~master_clk;

  sprite_ram_dma_if #(.ADDR_W(ADDR_W), .REC_SHIFT(REC_SHIFT)) bus ();

  sprite_ram_dma #(.ADDR_W(ADDR_W), .REC_SHIFT(REC_SHIFT), .END_MARK(8'hFF)) dut (
    .master_clk(master_clk),
    .nRESET    (nRESET),
    .bus       (bus)
  );

  // Work RAM: data is presented while the read strobe is up, junk otherwise.
  logic [7:0] src_mem [DEPTH];
  assign bus.src_data = bus.src_rd ? src_mem[bus.src_addr] : 8'h3C;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_rd = -1, first_rd_addr = -1, first_we = -1, done_cnt = 0;
  int exp_rec = 0;
  logic [ADDR_W+7:0] got_q[$];
  logic [ADDR_W+7:0] exp_q[$];

  always @(posedge master_clk) cyc <= cyc + 1;

  always @(negedge master_clk) begin
    if (bus.spr_we) got_q.push_back({bus.spr_addr, bus.spr_data});
    if (bus.src_rd && first_rd < 0) begin
      first_rd      = cyc;
      first_rd_addr = int'(bus.src_addr);
    end
    if (bus.spr_we && first_we < 0) first_we = cyc;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.dma_req, bus.src_rd, bus.src_addr, bus.spr_we, bus.spr_addr,
                bus.spr_data, bus.busy, bus.done, bus.rec_count, bus.overrun});
  endfunction

  // Reference: bytes are copied in address order up to and including the first
  // record whose first byte is the marker, otherwise through the last address.
  task automatic build_expected();
    exp_q.delete();
    exp_rec = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back({ADDR_W'(a), src_mem[a]});
      if (a % REC_BYTES == 0) begin
        if (src_mem[a] == 8'hFF) break;
        exp_rec++;
      end
    end
`ifdef SPR_DMA_CLEAR_EN
    for (int a = exp_q.size(); a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), 8'h00});
`endif
  endtask

  function automatic int first_diff();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size())
      return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    return -1;
  endfunction

  task automatic fill_xor();
    for (int a = 0; a < DEPTH; a++) src_mem[a] = 8'(a) ^ 8'h5A;
  endtask

  task automatic fill_rand(input int marker);
    for (int a = 0; a < DEPTH; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (a % REC_BYTES == 0 && v == 8'hFF) v = 8'hFE;
      src_mem[a] = v;
    end
    if (marker >= 0) src_mem[marker] = 8'hFF;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    bus.vblank_start = 1'b0;
    bus.dma_ack = 1'b0;
    repeat (3) @(negedge master_clk);
    nRESET = 1'b1;
    @(negedge master_clk);
  endtask

  task automatic run_xfer(input string name, input int pause_addr, input bit rand_ack,
                          input bit vb_mid, input bit vb_done);
    bit seen_done = 1'b0;
    bit paused = 1'b0;
    int pw = 0, pr = 0;
    got_q.delete();
    first_rd = -1; first_rd_addr = -1; first_we = -1; done_cnt = 0;
    build_expected();
    bus.dma_ack = 1'b0;
    @(negedge master_clk); bus.vblank_start = 1'b1;
    @(negedge master_clk); bus.vblank_start = 1'b0;
    check({name, ":req_busy"}, {bus.dma_req, bus.busy}, 64'h3);
    check({name, ":req_reccount"}, bus.rec_count, 0);
    repeat ($urandom_range(1, 3)) @(negedge master_clk);
    check({name, ":req_hold"}, {bus.dma_req, bus.src_rd, bus.spr_we}, 64'h4);
    bus.dma_ack = 1'b1;
    for (int n = 0; n < LIMIT && !seen_done; n++) begin
      @(negedge master_clk);
      bus.vblank_start = 1'b0;
      if (bus.done) begin
        seen_done = 1'b1;
        if (vb_done) bus.vblank_start = 1'b1;
      end else if (pause_addr >= 0 && !paused && bus.src_rd && int'(bus.src_addr) == pause_addr) begin
        paused = 1'b1;
        bus.dma_ack = 1'b0;
        repeat (5) begin
          @(negedge master_clk);
          if (bus.spr_we) pw++;
          if (bus.src_rd) pr++;
        end
        bus.dma_ack = 1'b1;
      end else begin
        if (rand_ack) bus.dma_ack = ($urandom_range(0, 3) != 0);
        if (vb_mid && n == 300) bus.vblank_start = 1'b1;
      end
    end
    @(negedge master_clk);
    bus.vblank_start = 1'b0;
    check({name, ":done_seen"}, seen_done, 1);
    repeat (4) @(negedge master_clk);
    check({name, ":done_once"}, done_cnt, 1);
    check({name, ":idle_after"}, {bus.busy, bus.dma_req, bus.spr_we, bus.src_rd}, 0);
    check({name, ":write_count"}, got_q.size(), exp_q.size());
    check({name, ":write_first_diff"}, first_diff(), -1);
    check({name, ":rec_count"}, bus.rec_count, exp_rec);
    check({name, ":first_rd_addr"}, first_rd_addr, 0);
    check({name, ":write_latency"}, first_we, first_rd + 1);
    if (pause_addr >= 0) begin
      check({name, ":pause_hit"}, paused, 1);
      check({name, ":pause_writes"}, pw, 1);
      check({name, ":pause_reads"}, pr, 0);
    end
    bus.dma_ack = 1'b0;
  endtask

  initial begin
    bit found;
    bus.vblank_start = 1'b0;
    bus.dma_ack = 1'b0;
    nRESET = 1'b0;
    fill_xor();

    // Reset and quiet idle
    repeat (3) @(negedge master_clk);
    check("reset_outputs", out_vec(), 0);
    nRESET = 1'b1;
    bus.dma_ack = 1'b1;
    repeat (3) @(negedge master_clk);
    check("idle_outputs", out_vec(), 0);
    bus.dma_ack = 1'b0;

    // Full copy with no marker
    fill_xor();
    run_xfer("full", -1, 1'b0, 1'b0, 1'b0);
    check("full:rec_512", bus.rec_count, 512);
    check("full:overrun", bus.overrun, 0);

    // Marker at address 12, plus vblank_start landing on the done cycle
    fill_rand(12);
    run_xfer("marker", -1, 1'b0, 1'b0, 1'b1);
    check("marker:rec_3", bus.rec_count, 3);
    check("marker:done_vblank_overrun", bus.overrun, 1);

    do_reset();
    check("overrun_cleared", bus.overrun, 0);

    // Pause after reading address 100
    fill_rand(-1);
    run_xfer("pause", 100, 1'b0, 1'b0, 1'b0);

    // vblank_start mid-transfer
    fill_xor();
    run_xfer("overrun", -1, 1'b0, 1'b1, 1'b0);
    check("overrun:flag", bus.overrun, 1);
    repeat (10) @(negedge master_clk);
    check("overrun:sticky", bus.overrun, 1);

    // Reset while reading address 500, then a fresh randomized transfer
    fill_xor();
    found = 1'b0;
    @(negedge master_clk); bus.vblank_start = 1'b1;
    @(negedge master_clk); bus.vblank_start = 1'b0; bus.dma_ack = 1'b1;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge master_clk);
      if (bus.src_rd && bus.src_addr == 11'd500) found = 1'b1;
    end
    check("midreset:point_seen", found, 1);
    nRESET = 1'b0;
    @(negedge master_clk);
    check("midreset:outputs", out_vec(), 0);
    nRESET = 1'b1;
    bus.dma_ack = 1'b0;
    @(negedge master_clk);
    check("midreset:stays_idle", {bus.busy, bus.dma_req, bus.spr_we}, 0);
    fill_rand(REC_BYTES * $urandom_range(1, DEPTH / REC_BYTES - 1));
    run_xfer("restart", -1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
